// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and types for the load/store sequencer
//
// Purpose: funct3 encodings, sequencer state enum, strobe width and the
//          funct3 legality helper used by lsu_ctrl and load_extend.
// Ports:   none (package).
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Unsigned variants only make sense for loads, so they are illegal with we=1.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic w);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return w;
            default:          return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_load_extend.sv
// rtl/lsu_ctrl_load_extend.sv - load lane select and sign/zero extension
//
// Purpose: picks the addressed byte/half out of the bus word and extends it.
// Ports:   funct3    in  3   access size/sign
//          addr      in  2   low byte-address bits
//          mem_rdata in  32  raw bus word
//          result    out 32  extended load value
module load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = mem_rdata[{addr, 3'b000} +: 8];
        lane_h = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_BU:   result = {24'h0, lane_b};
            F3_HU:   result = {16'h0, lane_h};
            default: result = mem_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer between core memory stage and data bus
//
// Purpose: sequences one load/store per request over a valid/ready bus,
//          stalls the core while in flight, builds strobes/replicated store
//          data, extends load data, and flags illegal funct3 or bus timeout.
//          Optional macro MISALIGN_TRAP_EN traps misaligned half/word accesses.
// Ports:   clk, reset (async, active-high)
//          req, we, funct3[2:0], addr[31:0], wdata[31:0]   core request
//          stall, done, rdata[31:0], err, misalign          core response
//          mem_valid, mem_ready, mem_we, mem_addr[31:0],
//          mem_wstrb[3:0], mem_wdata[31:0], mem_rdata[31:0] data bus
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              misalign,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state, state_nx;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [31:0]     addr_q, wdata_q, rdata_q, ext;
    logic [CW-1:0]   cnt;
    logic            err_q, err_nx, mis_q, mis_nx;
    logic            bad_align, tmo, hs;
    logic [STRB_W-1:0] strb;

    load_extend u_ext (
        .funct3    (f3_q),
        .addr      (addr_q[1:0]),
        .mem_rdata (mem_rdata),
        .result    (ext)
    );

`ifdef MISALIGN_TRAP_EN
    assign bad_align = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0])
                     || ((funct3 == F3_W) && (addr[1:0] != 2'b00));
`else
    assign bad_align = 1'b0;
`endif

    // mem_valid is purely a decode of state so an async reset drops it at once.
    assign tmo       = (cnt == CW'(TIMEOUT));
    assign mem_valid = (state == REQ) && !tmo;
    assign hs        = mem_valid && mem_ready;

    always_comb begin
        state_nx = state;
        err_nx   = 1'b0;
        mis_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (f3_illegal(funct3, we)) begin
                        state_nx = DONE;
                        err_nx   = 1'b1;
                    end else if (bad_align) begin
                        state_nx = DONE;
                        mis_nx   = 1'b1;
                    end else begin
                        state_nx = REQ;
                    end
                end
            end
            REQ: begin
                if (hs) begin
                    state_nx = DONE;
                end else if (tmo) begin
                    state_nx = DONE;
                    err_nx   = 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            cnt     <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= err_nx;
            mis_q <= mis_nx;
            if (state == IDLE && req) begin
                we_q    <= we;
                f3_q    <= funct3;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state == REQ && !hs && !tmo) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            // Only a completed load returns data; every other path into DONE reports zero.
            if (state_nx == DONE) begin
                rdata_q <= (hs && !we_q) ? ext : 32'h0;
            end
        end
    end

    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                strb      = 4'b0001 << addr_q[1:0];
                mem_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                strb      = addr_q[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                strb      = 4'b1111;
                mem_wdata = wdata_q;
            end
        endcase
    end

    assign mem_we    = (state == REQ) && we_q;
    assign mem_wstrb = mem_we ? strb : '0;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign done      = (state == DONE);
    assign stall     = ((state == IDLE) && req) || (state == REQ);
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign misalign  = mis_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0, we = 1'b0, mem_ready = 1'b1;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0, wdata = 32'h0, mem_rdata = 32'h0;
    logic        stall, done, err, misalign, mem_valid, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    int errors = 0;
    int checks = 0;

    // results of the most recent access
    logic        r_done, r_err, r_mis, r_mv_at_done;
    logic [31:0] r_rdata, c_addr, c_wdata;
    logic [3:0]  c_wstrb;
    logic        c_we;
    int          r_vcnt, r_cyc, r_stall_cnt;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
        .err(err), .misalign(misalign), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Issues one request cycle and observes until done (bounded). r_cyc counts
    // sampled cycles starting at the request cycle T0, so done@T2 gives 3.
    task automatic run(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
        @(posedge clk); #1;
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
        r_done = 1'b0; r_err = 1'b0; r_mis = 1'b0; r_rdata = 32'hx;
        r_vcnt = 0; r_cyc = 0; r_stall_cnt = 0; r_mv_at_done = 1'bx;
        c_addr = 32'hx; c_wdata = 32'hx; c_wstrb = 4'hx; c_we = 1'bx;
        for (int i = 0; i < 40 && !r_done; i++) begin
            @(negedge clk);
            r_cyc++;
            if (stall) r_stall_cnt++;
            if (mem_valid) begin
                r_vcnt++;
                c_addr = mem_addr; c_wdata = mem_wdata; c_wstrb = mem_wstrb; c_we = mem_we;
            end
            if (done) begin
                r_done = 1'b1; r_err = err; r_mis = misalign;
                r_rdata = rdata; r_mv_at_done = mem_valid;
            end
            @(posedge clk); #1;
            req = 1'b0;
        end
        checks++;
        if (r_done !== 1'b1) begin
            errors++;
            $display("FAIL run_timeout: done=%b required 1 within 40 cycles", r_done);
        end
    endtask

    task automatic test_reset;
        #2;
        checks++; if (mem_valid !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_ctl: valid=%b stall=%b done=%b required 0 0 0", mem_valid, stall, done);
        end
        checks++; if (err !== 1'b0 || misalign !== 1'b0 || mem_we !== 1'b0 || mem_wstrb !== 4'h0 || rdata !== 32'h0) begin
            errors++; $display("FAIL reset_out: err=%b mis=%b we=%b strb=%h rdata=%h required zeros", err, misalign, mem_we, mem_wstrb, rdata);
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_lw;
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        run(1'b0, 3'b010, 32'h100, 32'h0);
        checks++; if (r_cyc !== 3) begin errors++; $display("FAIL lw_latency: done at sample %0d required 3", r_cyc); end
        checks++; if (r_stall_cnt !== 2) begin errors++; $display("FAIL lw_stall: stall cycles %0d required 2", r_stall_cnt); end
        checks++; if (r_rdata !== 32'hDEADBEEF || r_err !== 1'b0) begin
            errors++; $display("FAIL lw_data: rdata=%h err=%b required deadbeef 0", r_rdata, r_err);
        end
        checks++; if (c_addr !== 32'h100 || c_wstrb !== 4'h0 || c_we !== 1'b0) begin
            errors++; $display("FAIL lw_bus: addr=%h strb=%h we=%b required 100 0 0", c_addr, c_wstrb, c_we);
        end
    endtask

    task automatic test_load_ext;
        logic [2:0]  f3v [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010};
        logic [31:0] av  [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101};
`ifdef MISALIGN_TRAP_EN
        logic [31:0] ev  [5] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF, 32'h0};
`else
        logic [31:0] ev  [5] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF, 32'h80FF1234};
`endif
        mem_rdata = 32'h80FF1234;
        for (int i = 0; i < 5; i++) begin
            run(1'b0, f3v[i], av[i], 32'h0);
            checks++; if (r_rdata !== ev[i]) begin
                errors++; $display("FAIL load_ext_%0d: rdata=%h required %h", i, r_rdata, ev[i]);
            end
        end
    endtask

    task automatic test_store;
        logic [2:0]  f3v [3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] av  [3] = '{32'h202, 32'h201, 32'h303};
        logic [31:0] wv  [3] = '{32'h0000ABCD, 32'h1234565A, 32'h12345678};
        logic [3:0]  sv  [3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] dv  [3] = '{32'hABCDABCD, 32'h5A5A5A5A, 32'h12345678};
        logic [31:0] mav [3] = '{32'h200, 32'h200, 32'h300};
`ifdef MISALIGN_TRAP_EN
        av[2] = 32'h300;
`endif
        for (int i = 0; i < 3; i++) begin
            run(1'b1, f3v[i], av[i], wv[i]);
            checks++; if (c_wstrb !== sv[i] || c_wdata !== dv[i]) begin
                errors++; $display("FAIL store_%0d: strb=%b wdata=%h required %b %h", i, c_wstrb, c_wdata, sv[i], dv[i]);
            end
            checks++; if (c_addr !== mav[i] || c_we !== 1'b1 || r_err !== 1'b0) begin
                errors++; $display("FAIL store_bus_%0d: addr=%h we=%b err=%b required %h 1 0", i, c_addr, c_we, r_err, mav[i]);
            end
        end
    endtask

    task automatic test_timeout;
        mem_ready = 1'b0;
        run(1'b1, 3'b010, 32'h400, 32'h1);
        checks++; if (r_vcnt !== 4) begin errors++; $display("FAIL tmo_valid: valid cycles %0d required 4", r_vcnt); end
        checks++; if (r_err !== 1'b1 || r_mv_at_done !== 1'b0) begin
            errors++; $display("FAIL tmo_err: err=%b valid=%b required 1 0", r_err, r_mv_at_done);
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_illegal;
        run(1'b0, 3'b011, 32'h100, 32'h0);
        checks++; if (r_cyc !== 2 || r_err !== 1'b1 || r_vcnt !== 0 || r_rdata !== 32'h0) begin
            errors++; $display("FAIL illegal_ld: cyc=%0d err=%b valid=%0d rdata=%h required 2 1 0 0", r_cyc, r_err, r_vcnt, r_rdata);
        end
        run(1'b1, 3'b100, 32'h100, 32'h0);
        checks++; if (r_err !== 1'b1 || r_vcnt !== 0) begin
            errors++; $display("FAIL illegal_st: err=%b valid=%0d required 1 0", r_err, r_vcnt);
        end
        run(1'b0, 3'b010, 32'h101, 32'h0);
`ifdef MISALIGN_TRAP_EN
        checks++; if (r_mis !== 1'b1 || r_err !== 1'b0 || r_vcnt !== 0) begin
            errors++; $display("FAIL misalign: mis=%b err=%b valid=%0d required 1 0 0", r_mis, r_err, r_vcnt);
        end
`else
        checks++; if (r_mis !== 1'b0 || r_err !== 1'b0 || r_vcnt !== 1) begin
            errors++; $display("FAIL misalign_off: mis=%b err=%b valid=%0d required 0 0 1", r_mis, r_err, r_vcnt);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int seen_done;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h500;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: valid=%b required 1", mem_valid); end
        #2 reset = 1'b1;
        #1;
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_async: valid=%b required 0", mem_valid); end
        seen_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) seen_done++;
            if (i == 0) reset = 1'b0;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL rst_mid_done: done pulses %0d required 0", seen_done); end
        mem_ready = 1'b1;
        run(1'b1, 3'b010, 32'h300, 32'hCAFEF00D);
        checks++; if (r_cyc !== 3 || r_err !== 1'b0 || c_wstrb !== 4'hF || c_addr !== 32'h300 || c_wdata !== 32'hCAFEF00D) begin
            errors++; $display("FAIL rst_mid_after: cyc=%0d err=%b strb=%h addr=%h wdata=%h required 3 0 f 300 cafef00d",
                               r_cyc, r_err, c_wstrb, c_addr, c_wdata);
        end
    endtask

    initial begin
        test_reset;
        test_lw;
        test_load_ext;
        test_store;
        test_timeout;
        test_illegal;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the core's memory-stage control (MemWrite, load ResultSrc, funct3) and a valid/ready data-memory bus.
- Stalls the core while an access is in flight.
- Generates byte strobes and lane-replicated write data, and returns sign/zero-extended load data.
- Adds a bus timeout and illegal-funct3 detection.

Parameters:
- TIMEOUT, 255: maximum cycles in REQ waiting for mem_ready before aborting with err; counter width is clog2(TIMEOUT+1).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  1  core requests a memory access (load or store)
- we  input  1  1 = store, 0 = load; sampled with req in IDLE
- funct3  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- addr  input  32  byte address
- wdata  input  32  store data (low bits significant)
- stall  output  1  hold core pipeline/PC
- done  output  1  one-cycle pulse; access complete
- rdata  output  32  extended load data, valid while done=1
- err  output  1  valid with done: illegal funct3 or timeout
- misalign  output  1  valid with done: misaligned access (feature only)
- mem_valid  output  1  bus request
- mem_ready  input  1  bus accept/complete
- mem_we  output  1  bus write enable
- mem_addr  output  32  {addr[31:2],2'b00}
- mem_wstrb  output  4  byte-lane strobes, 0000 on loads
- mem_wdata  output  32  lane-replicated store data
- mem_rdata  input  32  bus read data, sampled when mem_valid&mem_ready

Behaviour:
- Reset values: state=IDLE; stall=0, done=0, err=0, misalign=0, mem_valid=0, mem_we=0, mem_wstrb=0, rdata=0, timeout counter=0.
- States:
  - IDLE:
    - stall = req (combinational).
    - On req, latch we, funct3, addr, wdata.
    - Illegal funct3 (011, 110, 111; or 1xx with we=1): go to DONE with err=1, no bus access.
    - Otherwise go to REQ.
  - REQ:
    - mem_valid=1; mem_we, mem_addr, mem_wstrb and mem_wdata come from latched values and stay stable until the handshake.
    - On mem_valid&mem_ready: capture extended mem_rdata into rdata (loads) and go to DONE.
    - Counter increments each cycle without ready. When counter==TIMEOUT: drop mem_valid, go to DONE with err=1, rdata=0.
    - stall=1.
  - DONE:
    - done=1, stall=0; err/misalign reflect the access.
    - Next state is IDLE unconditionally.
    - Counter cleared.
    - If req is still high the following cycle, it is a new access.
- Latency: zero-wait bus gives req@T0, mem_valid@T1, done@T2, i.e. stall high for 2 cycles.
- Strobes and write data:
  - sb: wstrb = 1<<addr[1:0]; wdata byte replicated ×4.
  - sh: wstrb = addr[1] ? 1100 : 0011; half replicated ×2.
  - sw: wstrb = 1111.
- Load extension:
  - Select lane by addr[1:0] (byte) or addr[1] (half).
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- Alignment without feature: half ignores addr[0]; word ignores addr[1:0].
- Reset mid-access: mem_valid drops immediately (asynchronous); the in-flight transaction is abandoned and no done pulse is issued.
- mem_ready outside REQ is ignored.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Halfword with addr[0]=1, or word with addr[1:0]≠00, goes from IDLE to DONE with misalign=1, err=0, no bus access, rdata=0.
- Undefined:
  - misalign is tied 0.
  - Low address bits are ignored as described under alignment.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - State enum IDLE/REQ/DONE.
  - Strobe width constant.
- Sub-module load_extend: combinational lane select plus sign/zero extension, with inputs funct3, addr[1:0], mem_rdata and output 32-bit result.

Test Plan:
- lw at 0x100, mem_rdata=0xDEADBEEF, ready same cycle as valid: done@T2, rdata=0xDEADBEEF, stall high T0–T1, err=0.
- lb at 0x103 with mem_rdata=0x80FF_1234: rdata=0xFFFFFF80. lbu at the same address: rdata=0x00000080. lhu at 0x102: rdata=0x000080FF.
- sh at 0x202, wdata=0x0000ABCD: mem_wstrb=1100, mem_wdata=0xABCDABCD, mem_addr=0x200, mem_we=1.
- Store with mem_ready held low and TIMEOUT=4: mem_valid high exactly 4 cycles, then done=1 with err=1, mem_valid=0.
- funct3=011 load: done next cycle with err=1, mem_valid never asserted. With MISALIGN_TRAP_EN, lw at 0x101: misalign=1, no bus access.
- Assert reset while in REQ: mem_valid falls without waiting for clk, no done pulse; a subsequent sw at 0x300 completes normally.
